// File: rtl/datapath_if.sv
// Strobe and data bundle between the control unit and the single-bus datapath.
// Bit n of Rin/Rout is the R<n>in/R<n>out strobe.
interface datapath_if;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, IRin, HIin, LOin, MARin, Yin, ZHighin, ZLowin, MDRin, OutPort, Cin;
    logic        PCout, HIout, LOout, MDRout, MARout, ZHighout, ZLowout, InPort, Cout;
    logic        Read;
    logic [31:0] Mdatain;
    logic        IncPC;
    logic [4:0]  OP;

    modport master (
        output Rin, Rout, PCin, IRin, HIin, LOin, MARin, Yin, ZHighin, ZLowin, MDRin,
               OutPort, Cin, PCout, HIout, LOout, MDRout, MARout, ZHighout, ZLowout,
               InPort, Cout, Read, Mdatain, IncPC, OP
    );
    modport slave (
        input  Rin, Rout, PCin, IRin, HIin, LOin, MARin, Yin, ZHighin, ZLowin, MDRin,
               OutPort, Cin, PCout, HIout, LOout, MDRout, MARout, ZHighout, ZLowout,
               InPort, Cout, Read, Mdatain, IncPC, OP
    );
endinterface

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath: 16 GPRs, PC, IR, HI/LO, MAR/MDR, Y, 64-bit Z and ALU.
// Register names match the probe names used by the control-unit bring-up benches.
module datapath (
    input  logic       Clock,
    input  logic       Clear,
    datapath_if.slave  dp
);
    logic [31:0] R [16];
    logic [31:0] PC, IR, HI, LO, MAR, MDR, Y, OutReg;
    logic [63:0] Z;
    logic [31:0] BusMuxOut;
    logic [63:0] alu_result;

    logic [31:0] c_sext;
    logic [4:0]  shamt;
    logic [63:0] y_dbl, ror_full, rol_full;
    logic signed [63:0] y_ext, b_ext, prod;
    logic signed [31:0] quo, rem;

    assign c_sext = {{13{IR[18]}}, IR[18:0]};

    // Sources are applied lowest priority first so R0out ends up winning.
    always_comb begin
        BusMuxOut = '0;
        if (dp.Cout)     BusMuxOut = c_sext;
        if (dp.InPort)   BusMuxOut = 32'd0;
        if (dp.ZLowout)  BusMuxOut = Z[31:0];
        if (dp.ZHighout) BusMuxOut = Z[63:32];
        if (dp.MARout)   BusMuxOut = MAR;
        if (dp.MDRout)   BusMuxOut = MDR;
        if (dp.LOout)    BusMuxOut = LO;
        if (dp.HIout)    BusMuxOut = HI;
        if (dp.PCout)    BusMuxOut = PC;
        for (int i = 15; i >= 0; i--) begin
            if (dp.Rout[i]) BusMuxOut = R[i];
        end
    end

    assign shamt    = BusMuxOut[4:0];
    assign y_dbl    = {Y, Y};
    assign ror_full = y_dbl >> shamt;
    assign rol_full = y_dbl << shamt;
    assign y_ext    = {{32{Y[31]}}, Y};
    assign b_ext    = {{32{BusMuxOut[31]}}, BusMuxOut};
    assign prod     = y_ext * b_ext;

    // Divide-by-zero and the single overflow case are pinned so the result never depends on the simulator.
    always_comb begin
        quo = '0;
        rem = '0;
        if (BusMuxOut == 32'd0) begin
            quo = -32'sd1;
            rem = $signed(Y);
        end else if (Y == 32'h8000_0000 && BusMuxOut == 32'hFFFF_FFFF) begin
            quo = $signed(32'h8000_0000);
            rem = '0;
        end else begin
            quo = $signed(Y) / $signed(BusMuxOut);
            rem = $signed(Y) % $signed(BusMuxOut);
        end
    end

    always_comb begin
        alu_result = '0;
        case (dp.OP)
            5'b00000: alu_result = {32'd0, Y & BusMuxOut};
            5'b00001: alu_result = {32'd0, Y | BusMuxOut};
            5'b00010: alu_result = {32'd0, Y + BusMuxOut};
            5'b00011: alu_result = {32'd0, Y - BusMuxOut};
            5'b00100: alu_result = {32'd0, Y >> shamt};
            5'b00101: alu_result = {32'd0, $unsigned($signed(Y) >>> shamt)};
            5'b00110: alu_result = {32'd0, Y << shamt};
            5'b00111: alu_result = {32'd0, ror_full[31:0]};
            5'b01000: alu_result = {32'd0, rol_full[63:32]};
            5'b01001: alu_result = prod;
            5'b01010: alu_result = {rem, quo};
            5'b01011: alu_result = {32'd0, 32'd0 - BusMuxOut};
            5'b01100: alu_result = {32'd0, ~BusMuxOut};
            default:  alu_result = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) R[i] <= '0;
            PC     <= '0;
            IR     <= '0;
            HI     <= '0;
            LO     <= '0;
            MAR    <= '0;
            MDR    <= '0;
            Y      <= '0;
            Z      <= '0;
            OutReg <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (dp.Rin[i]) R[i] <= BusMuxOut;
            end
            if (dp.IncPC)        PC <= PC + 32'd1;
            else if (dp.PCin)    PC <= BusMuxOut;
            if (dp.IRin)         IR <= BusMuxOut;
            if (dp.HIin)         HI <= BusMuxOut;
            if (dp.LOin)         LO <= BusMuxOut;
            if (dp.MARin)        MAR <= BusMuxOut;
            if (dp.MDRin)        MDR <= dp.Read ? dp.Mdatain : BusMuxOut;
            if (dp.Yin)          Y <= BusMuxOut;
            if (dp.ZLowin)       Z[31:0] <= alu_result[31:0];
            if (dp.ZHighin)      Z[63:32] <= alu_result[63:32];
            if (dp.OutPort)      OutReg <= BusMuxOut;
        end
    end

    // Cin is reserved; OutReg and upper IR bits have no consumer inside this block.
    logic unused_sink;
    assign unused_sink = ^{dp.Cin, IR[31:19], OutReg};
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: expectations are queued when a step is issued and
// popped when the corresponding register is probed.
module tb_datapath;
    logic Clock;
    logic Clear;
    datapath_if dp ();

    datapath dut (
        .Clock (Clock),
        .Clear (Clear),
        .dp    (dp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        dp.Rin = '0; dp.Rout = '0;
        dp.PCin = 0; dp.IRin = 0; dp.HIin = 0; dp.LOin = 0; dp.MARin = 0; dp.Yin = 0;
        dp.ZHighin = 0; dp.ZLowin = 0; dp.MDRin = 0; dp.OutPort = 0; dp.Cin = 0;
        dp.PCout = 0; dp.HIout = 0; dp.LOout = 0; dp.MDRout = 0; dp.MARout = 0;
        dp.ZHighout = 0; dp.ZLowout = 0; dp.InPort = 0; dp.Cout = 0;
        dp.Read = 0; dp.IncPC = 0; dp.OP = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic load_r(input int idx, input logic [31:0] val);
        dp.Mdatain = val; dp.Read = 1; dp.MDRin = 1;
        step();
        dp.MDRout = 1; dp.Rin[idx] = 1;
        step();
    endtask

    task automatic load_ir(input logic [31:0] val);
        dp.Mdatain = val; dp.Read = 1; dp.MDRin = 1;
        step();
        dp.MDRout = 1; dp.IRin = 1;
        step();
    endtask

    task automatic alu(input int a_reg, input int b_reg, input logic [4:0] op);
        dp.Rout[a_reg] = 1; dp.Yin = 1;
        step();
        dp.Rout[b_reg] = 1; dp.OP = op; dp.ZLowin = 1; dp.ZHighin = 1;
        step();
    endtask

    initial begin
        Clear = 1'b0;
        dp.Mdatain = '0;
        idle();
        repeat (2) @(posedge Clock);
        #1;
        push("reset_r5", 64'd0); check({32'd0, dut.R[5]});
        push("reset_pc", 64'd0); check({32'd0, dut.PC});
        push("reset_z",  64'd0); check(dut.Z);
        push("idle_bus", 64'd0); check({32'd0, dut.BusMuxOut});
        Clear = 1'b1;
        step();

        // Populate R5, PC and Z, then pulse Clear between edges.
        load_r(5, 32'h0000_AAAA);
        push("load_r5", 64'h0000_AAAA); check({32'd0, dut.R[5]});
        dp.IncPC = 1;
        step();
        push("pc_inc", 64'd1); check({32'd0, dut.PC});
        alu(0, 5, 5'b00001);
        push("or_z", 64'h0000_AAAA); check(dut.Z);
        #2 Clear = 1'b0;
        #1;
        push("clr_r5", 64'd0); check({32'd0, dut.R[5]});
        push("clr_pc", 64'd0); check({32'd0, dut.PC});
        push("clr_z",  64'd0); check(dut.Z);
        #1 Clear = 1'b1;
        step();

        // AND program
        load_r(2, 32'h12);
        load_r(3, 32'h14);
        load_r(1, 32'h18);
        load_ir(32'h2891_8000);
        push("ir_load", 64'h2891_8000); check({32'd0, dut.IR});
        alu(2, 3, 5'b00000);
        push("and_z", 64'h10); check(dut.Z);
        dp.ZLowout = 1; dp.Rin[1] = 1;
        step();
        push("and_r1", 64'h10); check({32'd0, dut.R[1]});

        // ADD / SUB
        load_r(4, 32'hFFFF_FFFF);
        load_r(6, 32'd1);
        alu(4, 6, 5'b00010);
        push("add_wrap", 64'd0); check(dut.Z);
        alu(4, 6, 5'b00011);
        push("sub", 64'h0000_0000_FFFF_FFFE); check(dut.Z);

        // MUL / DIV
        load_r(6, 32'd2);
        alu(4, 6, 5'b01001);
        push("mul_neg", 64'hFFFF_FFFF_FFFF_FFFE); check(dut.Z);
        load_r(7, 32'd7);
        alu(7, 6, 5'b01010);
        push("div", 64'h0000_0001_0000_0003); check(dut.Z);
        load_r(8, 32'd0);
        alu(7, 8, 5'b01010);
        push("div_zero", 64'h0000_0007_FFFF_FFFF); check(dut.Z);

        // PC
        dp.Rout[8] = 1; dp.PCin = 1;
        step();
        push("pc_load0", 64'd0); check({32'd0, dut.PC});
        dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1;
        step();
        push("mar_old_pc", 64'd0); check({32'd0, dut.MAR});
        push("pc_plus1",   64'd1); check({32'd0, dut.PC});
        dp.Rout[4] = 1; dp.PCin = 1;
        step();
        dp.IncPC = 1;
        step();
        push("pc_wrap", 64'd0); check({32'd0, dut.PC});
        dp.Rout[6] = 1; dp.PCin = 1; dp.IncPC = 1;
        step();
        push("incpc_prio", 64'd1); check({32'd0, dut.PC});

        // Cout and shifts
        dp.Cout = 1; dp.Yin = 1;
        step();
        push("cout_pos", 64'h0001_8000); check({32'd0, dut.Y});
        load_r(10, 32'h8000_0001);
        load_r(11, 32'd1);
        alu(10, 11, 5'b00101);
        push("shra", 64'hC000_0000); check(dut.Z);
        alu(10, 11, 5'b00111);
        push("ror", 64'hC000_0000); check(dut.Z);
        alu(10, 11, 5'b00110);
        push("shl", 64'h2); check(dut.Z);
        alu(10, 11, 5'b01000);
        push("rol", 64'h3); check(dut.Z);
        alu(10, 11, 5'b01101);
        push("bad_op", 64'd0); check(dut.Z);

        // Bus priority, same-register load/drive, OutPort, HI/LO paths
        load_r(0, 32'h55);
        dp.Rout[0] = 1; dp.Rout[1] = 1; dp.Yin = 1;
        step();
        push("bus_prio", 64'h55); check({32'd0, dut.Y});
        dp.Rout[1] = 1; dp.Rin[1] = 1;
        step();
        push("self_load", 64'h10); check({32'd0, dut.R[1]});
        dp.Rout[1] = 1; dp.OutPort = 1;
        step();
        push("outreg", 64'h10); check({32'd0, dut.OutReg});
        dp.Rout[7] = 1; dp.HIin = 1;
        step();
        dp.HIout = 1; dp.LOin = 1;
        step();
        push("hi_to_lo", 64'd7); check({32'd0, dut.LO});
        load_ir(32'h0004_0001);
        dp.Cout = 1; dp.Yin = 1;
        step();
        push("cout_neg", 64'hFFFC_0001); check({32'd0, dut.Y});

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
